// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between operand fetch, alu_mc and writeback.
// The master side issues operations and accepts results; the slave side is the ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, Op, in_valid, out_ready,
    input  in_ready, Y, C, V, N, Z, out_valid
  );

  modport slave (
    input  A, B, Op, in_valid, out_ready,
    output in_ready, Y, C, V, N, Z, out_valid
  );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: one operation in flight, registered result and flags,
// carry-chained ADC/SBB via an internal carry flag, and a WIDTH-step shift-add multiplier.
module alu_mc #(
  parameter  int WIDTH = 16,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);

  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;
  localparam logic [3:0] OP_SBB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
  } res_t;

  // Single-cycle result for every op except MUL. Shifts pad one guard bit so the
  // last bit shifted out lands in a fixed position and becomes the carry.
  function automatic res_t alu_op(input logic [3:0]       op,
                                  input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic             cf_in);
    res_t                    r;
    logic [WIDTH:0]          wide;
    logic signed [WIDTH:0]   sw;
    logic [SH_W-1:0]         s;
    logic                    ci;
    r    = '0;
    wide = '0;
    sw   = '0;
    s    = b[SH_W-1:0];
    ci   = ((op == OP_ADC) || (op == OP_SBB)) ? cf_in : 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        r.y  = wide[WIDTH-1:0];
        r.c  = wide[WIDTH];
        r.v  = (a[WIDTH-1] == b[WIDTH-1]) && (r.y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
        r.y  = wide[WIDTH-1:0];
        r.c  = wide[WIDTH];
        r.v  = (a[WIDTH-1] != b[WIDTH-1]) && (r.y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r.y = a & b;
      OP_OR:  r.y = a | b;
      OP_XOR: r.y = a ^ b;
      OP_NOT: r.y = ~a;
      OP_SHL: begin
        wide = {1'b0, a} << s;
        r.y  = wide[WIDTH-1:0];
        r.c  = wide[WIDTH];
      end
      OP_ASR: begin
        sw  = $signed({a, 1'b0}) >>> s;
        r.y = sw[WIDTH:1];
        r.c = sw[0];
      end
      OP_LSR: begin
        wide = {a, 1'b0} >> s;
        r.y  = wide[WIDTH:1];
        r.c  = wide[0];
      end
      default: ;
    endcase
    return r;
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [WIDTH-1:0]        mcand_p0;
  logic [2*WIDTH-1:0]      prod_p0;
  logic [2*WIDTH-1:0]      prod_nxt;
  logic [WIDTH:0]          psum;
  logic                    cf;
  logic                    accept;
  logic                    is_mul;
  logic                    mul_last;
  logic                    load;
  res_t                    fin;
  logic [WIDTH-1:0]        y_q;
  logic                    c_q, v_q, n_q, z_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_mul   = (bus.Op == OP_MUL);
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign mul_last = (state == BUSY) && (cnt_nxt == CNT_W'(WIDTH));

  // Multiplier step: prod holds {partial high half, remaining multiplier bits};
  // add the multiplicand when the current multiplier LSB is set, then shift right.
  assign psum     = {1'b0, prod_p0[2*WIDTH-1:WIDTH]} + (prod_p0[0] ? {1'b0, mcand_p0} : '0);
  assign prod_nxt = {psum, prod_p0[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul ? BUSY : DONE;
      BUSY:    if (mul_last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture at accept, multiplier iteration while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == BUSY) cnt <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0 <= bus.A;
      prod_p0  <= {{WIDTH{1'b0}}, bus.B};
    end else if (state == BUSY) begin
      prod_p0  <= prod_nxt;
    end
  end

  always_comb begin
    load = (accept && !is_mul) || mul_last;
    fin  = alu_op(bus.Op, bus.A, bus.B, cf);
    if (state == BUSY) begin
      fin.y = prod_nxt[WIDTH-1:0];
      fin.c = |prod_nxt[2*WIDTH-1:WIDTH];
      fin.v = 1'b0;
    end
  end

  // Stage p1: result and flag registers, updated only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      cf  <= 1'b0;
    end else if (load) begin
      y_q <= fin.y;
      c_q <= fin.c;
      v_q <= fin.v;
      n_q <= fin.y[WIDTH-1];
      z_q <= (fin.y == '0);
      cf  <= fin.c;
    end
  end

  assign bus.Y         = y_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.out_valid = (state == DONE);
  assign bus.in_ready  = (state == IDLE) && !rst;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table in issue order (cf chains between entries),
// then backpressure and reset-during-multiply sequences.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(16)) bus ();
  alu_mc #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic [3:0]  cvnz;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op (waits for in_ready), then count edges until out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [19:0] got, output int lat, output logic busy_ok);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    bus.Op = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    got = {bus.Y, bus.C, bus.V, bus.N, bus.Z};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] got;
    int          lat;
    logic        bok;
    logic        seen;

    vecs[0]  = {4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
    vecs[1]  = {4'd9,  16'h0001, 16'h0001, 16'h0003, 4'b0000};
    vecs[2]  = {4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
    vecs[3]  = {4'd1,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010};
    vecs[4]  = {4'd10, 16'h0005, 16'h0002, 16'h0002, 4'b0000};
    vecs[5]  = {4'd11, 16'h0100, 16'h0100, 16'h0000, 4'b1001};
    vecs[6]  = {4'd11, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000};
    vecs[7]  = {4'd7,  16'h8004, 16'h0002, 16'hE001, 4'b0010};
    vecs[8]  = {4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b1000};
    vecs[9]  = {4'd8,  16'h8001, 16'h000F, 16'h0001, 4'b0000};
    vecs[10] = {4'd6,  16'h1234, 16'h0010, 16'h1234, 4'b0000};
    vecs[11] = {4'd7,  16'h8765, 16'h0000, 16'h8765, 4'b0010};
    vecs[12] = {4'd13, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001};
    vecs[13] = {4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
    vecs[14] = {4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0, 4'b0010};
    vecs[15] = {4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001};
    vecs[16] = {4'd5,  16'h00FF, 16'h1234, 16'hFF00, 4'b0010};
    vecs[17] = {4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
    vecs[18] = {4'd9,  16'h0001, 16'h0001, 16'h0002, 4'b0000};
    vecs[19] = {4'd8,  16'h0003, 16'h0001, 16'h0001, 4'b1000};
    vecs[20] = {4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000};
    vecs[21] = {4'd7,  16'h8000, 16'h000F, 16'hFFFF, 4'b0010};
    vecs[22] = {4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
    vecs[23] = {4'd10, 16'h0000, 16'h0000, 16'hFFFF, 4'b1010};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.Op = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", 32'({bus.in_ready, bus.out_valid, bus.Y, bus.C, bus.V, bus.N, bus.Z}), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat, bok);
      chk($sformatf("vec%0d_result", i), 32'(got), 32'({vecs[i].y, vecs[i].cvnz}));
      chk($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].op == 4'd11) ? 32'd17 : 32'd1);
      if (vecs[i].op == 4'd11) chk($sformatf("vec%0d_ready_low_busy", i), 32'(bok), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_consume", i), 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end

    // Backpressure: result must hold and new requests must be ignored
    bus.out_ready = 1'b0;
    run_op(4'd0, 16'h4000, 16'h4000, got, lat, bok);
    chk("bp_result", 32'(got), 32'({16'h8000, 4'b0110}));
    for (int i = 0; i < 5; i++) begin
      bus.Op = 4'd2; bus.A = 16'h0001; bus.B = 16'h0001; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i),
          32'({bus.Y, bus.C, bus.V, bus.N, bus.Z, bus.out_valid, bus.in_ready}),
          32'({16'h8000, 4'b0110, 1'b1, 1'b0}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({bus.out_valid, bus.in_ready, bus.Y}), 32'({1'b0, 1'b1, 16'h8000}));

    // Reset in the middle of a multiply, with cf set beforehand
    run_op(4'd0, 16'hFFFF, 16'h0001, got, lat, bok);
    chk("pre_rst_add", 32'(got), 32'({16'h0000, 4'b1001}));
    @(posedge clk); #1;
    bus.Op = 4'd11; bus.A = 16'h00FF; bus.B = 16'h00FF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_mul_still_busy", 32'({bus.out_valid, bus.in_ready}), 32'b00);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul", 32'({bus.out_valid, bus.in_ready, bus.Y, bus.C}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst_mul", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    chk("no_result_after_abort", 32'(seen), 32'd0);
    run_op(4'd9, 16'h0001, 16'h0001, got, lat, bok);
    chk("adc_cf_cleared", 32'(got), 32'({16'h0002, 4'b0000}));
    chk("adc_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
